divider_seq: RTL and testbench
==============================

Name: divider_seq

Overview:
- Multi-cycle iterative integer divider for the soft-processor ALU datapath. It serves MIPS DIV and DIVU.
- It is the inverse-operation companion of the single-cycle add/sub/slt unit: it performs one restoring-division step per clock (shift, trial-subtract, conditional restore).
- It delivers quotient (LO) and remainder (HI) with a fixed latency.
- The pipeline stall logic holds the issuing instruction while `busy` is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNTW, 6, width of the iteration counter; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- opA  input  WIDTH  dividend; sampled only on an accepted start.
- opB  input  WIDTH  divisor; sampled only on an accepted start.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with the operands.
- start  input  1  request a division; accepted only when `busy` = 0.
- busy  output  1  high from the cycle after an accepted start until `done`.
- done  output  1  one-cycle pulse; `quotient` and `remainder` are valid from this cycle on.
- quotient  output  WIDTH  registered quotient (LO); held until the next `done`.
- remainder  output  WIDTH  registered remainder (HI); held until the next `done`.

Behaviour:
- Reset (asynchronous, any state including mid-division):
  - state goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0.
  - internal accumulators and counter are cleared.
  - The in-flight operation is discarded with no `done`.
- States: IDLE, BUSY, FIX.
- IDLE:
  - On `start`=1 at edge k, latch |opA|, |opB|, is_signed, sign(opA), sign(opB), and the divisor-zero flag; set counter=WIDTH; go to BUSY.
  - Magnitudes are taken only when is_signed=1 and the operand MSB=1; otherwise the raw value is used.
  - busy=1 from edge k.
- BUSY:
  - Each edge performs one step: partial remainder R = {R[WIDTH-2:0], dividend MSB}; dividend shifts left.
  - Trial value T = R − divisor, computed at WIDTH+1 bits.
  - If T is non-negative: R=T and quotient bit=1. Otherwise R is kept and quotient bit=0.
  - Counter decrements; when it reaches 0 (after WIDTH steps, edges k+1..k+WIDTH) go to FIX.
- FIX (edge k+WIDTH+1): write the outputs, set done=1 and busy=0, go to IDLE.
  - Unsigned: quotient = Q, remainder = R.
  - Signed: quotient = Q negated if sign(opA) XOR sign(opB); remainder = R negated if sign(opA)=1.
  - Remainder therefore takes the sign of the dividend (truncating division).
- Latency: done is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+1 clocks after the start edge (33 for WIDTH=32). Latency is fixed and independent of the data.
- done is cleared on the next edge unless that edge is again a FIX edge.
- Divide by zero: full latency is still taken. quotient = all ones, remainder = opA as originally presented (unsigned and signed alike); the sign fixup is bypassed.
- Signed overflow (−2^(WIDTH−1) / −1): quotient = 0x80000000, remainder = 0. This is the natural result of the magnitude algorithm; no trap is raised.
- `start` while busy=1 is ignored; operands are not re-sampled and the current operation completes unchanged.
- `start` in the same cycle as `done` (state is IDLE) is accepted; back-to-back divisions have no dead cycle.
- Outputs change only at FIX edges or on reset.
- The internal datapath must be exactly WIDTH+1 bits for the trial subtract, with no wider arithmetic.

Test Plan:
- DIVU 100/7 (start at edge 0) -> busy=1 for cycles 1..32; done pulse at cycle 33; quotient=14, remainder=2; outputs unchanged 10 cycles later.
- DIV 0xFFFFFFF9/2 (−7/2) -> quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). DIV 7/0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- 0x80000000/0xFFFFFFFF: signed -> quotient=0x80000000, remainder=0. Unsigned -> quotient=0, remainder=0x80000000.
- Divide by zero: DIVU 0x1234/0 and DIV 0xFFFF0000/0 -> quotient=0xFFFFFFFF; remainder=0x1234 and 0xFFFF0000 respectively; done still at cycle 33.
- Start DIVU 50/5. Pulse start with 9/3 at cycle 5 -> ignored, first result quotient=10, remainder=0. Assert start with 9/3 in the done cycle -> second done exactly 33 cycles later with quotient=3, remainder=0.
- Assert reset asynchronously (between edges) at cycle 10 of a division -> busy, done, quotient and remainder go to 0 immediately. After release, no done ever appears for the aborted operation, and a new start works with normal latency.

Source files
------------

// File: rtl/divider_seq_if.sv
// rtl/divider_seq_if.sv - operand/result bundle for the sequential divider
//
// Purpose : groups the divider's request (operands, mode, start) and its
//           response (busy, done, quotient, remainder) into one bundle.
// Signals : opA/opB   dividend/divisor, sampled on an accepted start
//           is_signed 1 = DIV (two's complement), 0 = DIVU
//           start     request a division, accepted only while busy = 0
//           busy      operation in flight
//           done      one-cycle pulse, results valid from this cycle on
//           quotient  LO result, held until the next done
//           remainder HI result, held until the next done
// Modports: master = issuing pipeline, slave = divider

interface divider_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             is_signed;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output opA, opB, is_signed, start,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  opA, opB, is_signed, start,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - multi-cycle restoring integer divider (DIV/DIVU)
//
// Purpose : one restoring-division step per clock on operand magnitudes,
//           then a sign fixup cycle. Fixed latency of WIDTH+1 clocks from
//           the start edge to done; truncating signed division.
// Ports   : clk    system clock, rising edge
//           reset  asynchronous, active-high; aborts any operation
//           bus    divider_seq_if.slave (operands, start, busy, done, results)

module divider_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic          clk,
    input  logic          reset,
    divider_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    // dvd holds the dividend magnitude; quotient bits shift in at the LSB
    // as dividend bits shift out at the MSB, so it ends up holding Q.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;

    // The partial remainder stays below 2^(i) after step i, so its MSB is
    // always zero before the final shift and WIDTH+1 bits suffice.
    assign shifted = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    neg_a_d = bus.is_signed & bus.opA[WIDTH-1];
                    neg_b_d = bus.is_signed & bus.opB[WIDTH-1];
                    dvd_d   = neg_a_d ? -bus.opA : bus.opA;
                    dvs_d   = neg_b_d ? -bus.opB : bus.opB;
                    dz_d    = (bus.opB == '0);
                    rem_d   = '0;
                    cnt_d   = CNTW'(WIDTH);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // trial[WIDTH] set means the subtraction went negative: restore
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // With a zero divisor every step subtracts 0, leaving Q all
                // ones and R = |opA|; re-applying the dividend sign to R
                // restores opA exactly, so only the quotient fixup is skipped.
                quo_d   = ((neg_a_q ^ neg_b_q) & ~dz_q) ? -dvd_q : dvd_q;
                rmd_d   = neg_a_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;

endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - scoreboard testbench for divider_seq

module tb_divider_seq;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        int               cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t sb[$];

    divider_seq_if #(.WIDTH(WIDTH)) bus ();

    divider_seq #(.WIDTH(WIDTH), .CNTW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero and
    // overflow rules; SV signed '/' and '%' truncate toward zero.
    function automatic exp_t model(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic s);
        exp_t e;
        int sa, sbv;
        e.cyc = 0;
        sa  = a;
        sbv = b;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = '0;
        end else begin
            e.q = 32'(sa / sbv);
            e.r = 32'(sa % sbv);
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", bus.quotient, e.q);
                chk("remainder", bus.remainder, e.r);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; drives start across one rising edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s, input bit expect_accept);
        exp_t e;
        bus.opA       = a;
        bus.opB       = b;
        bus.is_signed = s;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (expect_accept) begin
            e     = model(a, b, s);
            e.cyc = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 200);
        if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    initial begin
        int k;
        logic [WIDTH-1:0] a, b;
        logic s;
        n_vec = 0;
        n_err = 0;
        bus.opA = '0;
        bus.opB = '0;
        bus.is_signed = 1'b0;
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // DIVU 100/7 with busy profile and output hold
        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        k = cyc;
        for (int i = 0; i <= WIDTH + 1; i++) begin
            @(negedge clk);
            chk("busy_profile", 32'(bus.busy), 32'(cyc <= k + WIDTH));
        end
        repeat (10) @(negedge clk);
        chk("hold_quotient", bus.quotient, 32'd14);
        chk("hold_remainder", bus.remainder, 32'd2);

        // signed cases, overflow and divide by zero
        @(negedge clk); start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1); wait_done();
        @(negedge clk); start_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1); wait_done();
        @(negedge clk); start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_done();
        @(negedge clk); start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_done();
        @(negedge clk); start_op(32'h1234, 32'd0, 1'b0, 1'b1); wait_done();
        @(negedge clk); start_op(32'hFFFF_0000, 32'd0, 1'b1, 1'b1); wait_done();

        // start while busy is ignored; start in done cycle is accepted
        @(negedge clk); start_op(32'd50, 32'd5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        start_op(32'd9, 32'd3, 1'b0, 1'b0);
        wait_done();
        start_op(32'd9, 32'd3, 1'b0, 1'b1);
        wait_done();

        // asynchronous reset mid-division
        @(negedge clk); start_op(32'd1000, 32'd3, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_quotient", bus.quotient, 32'd0);
        chk("abort_remainder", bus.remainder, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        start_op(32'd1000, 32'd3, 1'b0, 1'b1);
        wait_done();

        // randomized, mixing idle gaps and back-to-back issue
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom;
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = -32'($urandom_range(1, 100));
            endcase
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            start_op(a, b, s, 1'b1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
